// File: rtl/gated_clk_pkg.sv
// gated_clk_pkg: shared state type, default parameters and counter-width helper
package gated_clk_pkg;
  typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} ch_state_t;
  localparam int DEF_CH_NUM   = 4;
  localparam int DEF_HOLD_CYC = 8;
  localparam int DEF_WAKE_CYC = 2;
  function automatic int cnt_w(input int hold_cyc, input int wake_cyc);
    int m;
    int w;
    m = (hold_cyc > wake_cyc) ? hold_cyc : wake_cyc;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/gated_clk_ch.sv
// gated_clk_ch: one gated-clock channel, OFF/WAKE/ON/HOLD FSM with a wake/hold down-counter
module gated_clk_ch
  import gated_clk_pkg::*;
#(
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int CNT_W    = cnt_w(HOLD_CYC, WAKE_CYC)
) (
  input  logic clk_in,
  input  logic cpurst_b,
  input  logic i_req,
  output logic o_en,
  output logic o_ack,
  output logic o_off
);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);
  localparam ch_state_t ST_WAKE = (WAKE_CYC == 0) ? ON : WAKE;
  localparam ch_state_t ST_HOLD = (HOLD_CYC == 0) ? OFF : HOLD;
  ch_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_en, r_ack, r_off;
  // next state and counter; a request drop always wins over wake completion, loads win over decrements
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      OFF: if (i_req) begin
        w_state_nxt = ST_WAKE;
        w_cnt_nxt   = WAKE_LD;
      end
      WAKE: if (!i_req) begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = HOLD_LD;
      end else if (r_cnt == '0) w_state_nxt = ON;
      else w_cnt_nxt = r_cnt - 1'b1;
      ON: if (!i_req) begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = HOLD_LD;
      end
      HOLD: if (i_req) w_state_nxt = ON;
      else if (r_cnt == '0) w_state_nxt = OFF;
      else w_cnt_nxt = r_cnt - 1'b1;
      default: w_state_nxt = OFF;
    endcase
  end
  // state, counter and registered output decodes; reset aborts straight to OFF
  always_ff @(posedge clk_in) begin
    if (!cpurst_b) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_ack   <= 1'b0;
      r_off   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_state_nxt != OFF;
      r_ack   <= (w_state_nxt == ON) || (w_state_nxt == HOLD);
      r_off   <= w_state_nxt == OFF;
    end
  end
  assign o_en  = r_en;
  assign o_ack = r_ack;
  assign o_off = r_off;
endmodule

// File: rtl/gated_clk_ctrl.sv
// gated_clk_ctrl: request formation, per-channel gating FSMs, scan override and all-off summary
module gated_clk_ctrl
  import gated_clk_pkg::*;
#(
  parameter int CH_NUM   = DEF_CH_NUM,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int WAKE_CYC = DEF_WAKE_CYC
) (
  input  logic              clk_in,
  input  logic              cpurst_b,
  input  logic              global_en,
  input  logic [CH_NUM-1:0] module_en,
  input  logic [CH_NUM-1:0] local_en,
  input  logic [CH_NUM-1:0] external_en,
  input  logic [CH_NUM-1:0] force_on,
  input  logic              pad_yy_icg_scan_en,
  output logic [CH_NUM-1:0] clk_en,
  output logic [CH_NUM-1:0] clk_ack,
  output logic [CH_NUM-1:0] clk_off,
  output logic              all_off
);
  logic [CH_NUM-1:0] w_req, w_en;
  // per-channel request: gated enables, or either unconditional source
  always_comb w_req = ({CH_NUM{global_en}} & (module_en | local_en)) | external_en | force_on;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    gated_clk_ch #(.HOLD_CYC(HOLD_CYC), .WAKE_CYC(WAKE_CYC)) u_ch (
      .clk_in  (clk_in),
      .cpurst_b(cpurst_b),
      .i_req   (w_req[i]),
      .o_en    (w_en[i]),
      .o_ack   (clk_ack[i]),
      .o_off   (clk_off[i])
    );
  end
  // scan opens every gate without touching channel state; all_off only sees registered bits
  always_comb begin
    clk_en  = w_en | {CH_NUM{pad_yy_icg_scan_en}};
    all_off = &clk_off;
  end
endmodule
